// File: rtl/fp_exec_pipe_ctrl.sv
// rtl/fp_exec_pipe_ctrl.sv - per-lane FP execution pipeline control with multicycle unit arbitration
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stall, clear                back-end hold / invalidate-all
//   in_valid/in_reg_valid/in_multi/in_ptr/in_tag   per-lane issue into stage 0
//   flush_req/flush_all/flush_head/flush_tail      selective flush of pointer range [head, tail)
//   mc_done                     per-lane multicycle result ready (level)
//   mc_start/mc_busy            per-lane multicycle start pulse / reservation
//   out_*                       final-stage op per lane
//   replay_*                    stage-1 op whose operands were not ready
module fp_exec_pipe_ctrl #(
    parameter int LANES = 2,
    parameter int DEPTH = 3,
    parameter int PTR_W = 6,
    parameter int TAG_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     clear,
    input  logic [LANES-1:0]         in_valid,
    input  logic [LANES-1:0]         in_reg_valid,
    input  logic [LANES-1:0]         in_multi,
    input  logic [LANES*PTR_W-1:0]   in_ptr,
    input  logic [LANES*TAG_W-1:0]   in_tag,
    input  logic                     flush_req,
    input  logic                     flush_all,
    input  logic [PTR_W-1:0]         flush_head,
    input  logic [PTR_W-1:0]         flush_tail,
    input  logic [LANES-1:0]         mc_done,
    output logic [LANES-1:0]         mc_start,
    output logic [LANES-1:0]         mc_busy,
    output logic [LANES-1:0]         out_valid,
    output logic [LANES-1:0]         out_reg_valid,
    output logic [LANES*PTR_W-1:0]   out_ptr,
    output logic [LANES*TAG_W-1:0]   out_tag,
    output logic [LANES-1:0]         replay_valid,
    output logic [LANES*PTR_W-1:0]   replay_ptr,
    output logic [LANES*TAG_W-1:0]   replay_tag
);

    localparam int LAST = DEPTH - 1;
    localparam int RP   = (DEPTH > 1) ? 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} mc_state_t;

    // Range [head, tail) wraps when head > tail; head == tail is an empty range.
    function automatic logic flushed(input logic [PTR_W-1:0] p);
        if (!flush_req) return 1'b0;
        if (flush_all) return 1'b1;
        if (flush_head <= flush_tail) return (p >= flush_head) && (p < flush_tail);
        return (p >= flush_head) || (p < flush_tail);
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DEPTH-1:0] sv, srv, smu;
        logic [PTR_W-1:0] sp [DEPTH];
        logic [TAG_W-1:0] st [DEPTH];
        logic [PTR_W-1:0] lptr, owner;
        logic [TAG_W-1:0] ltag;
        mc_state_t        state, state_nx;
        logic             in_acc, start, s0_rv, release_op, owner_kill;

        assign lptr = in_ptr[l*PTR_W +: PTR_W];
        assign ltag = in_tag[l*TAG_W +: TAG_W];

        always_comb begin
            in_acc     = in_valid[l] && !stall && !clear && !flushed(lptr);
            start      = rst_n && in_acc && in_multi[l] && in_reg_valid[l] && (state == IDLE);
            release_op = out_valid[l] && smu[LAST] && srv[LAST] && (sp[LAST] == owner);
            owner_kill = clear || flushed(owner);
            // Multi ops only carry a valid result when the unit has finished
            // for exactly this pointer; everything else is sent round for replay.
            if (!in_multi[l])
                s0_rv = in_reg_valid[l];
            else if ((state == DONE) && (lptr == owner))
                s0_rv = in_reg_valid[l];
            else
                s0_rv = 1'b0;

            state_nx = state;
            case (state)
                IDLE:  if (start) state_nx = BUSY;
                BUSY: begin
                    if (owner_kill)      state_nx = mc_done[l] ? IDLE : DRAIN;
                    else if (mc_done[l]) state_nx = DONE;
                end
                DONE:  if (owner_kill || release_op) state_nx = IDLE;
                DRAIN: if (mc_done[l]) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state <= IDLE;
                owner <= '0;
            end else begin
                state <= state_nx;
                if (start) owner <= lptr;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sv  <= '0;
                srv <= '0;
                smu <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    sp[k] <= '0;
                    st[k] <= '0;
                end
            end else if (clear) begin
                sv  <= '0;
                srv <= '0;
            end else if (!stall) begin
                sv[0]  <= in_valid[l] && !flushed(lptr);
                srv[0] <= s0_rv;
                smu[0] <= in_multi[l];
                sp[0]  <= lptr;
                st[0]  <= ltag;
                for (int k = 1; k < DEPTH; k++) begin
                    sv[k]  <= sv[k-1] && !flushed(sp[k-1]);
                    srv[k] <= srv[k-1];
                    smu[k] <= smu[k-1];
                    sp[k]  <= sp[k-1];
                    st[k]  <= st[k-1];
                end
            end
        end

        assign mc_start[l]                   = start;
        assign mc_busy[l]                    = (state != IDLE);
        assign out_valid[l]                  = sv[LAST] && !stall && !clear && !flushed(sp[LAST]);
        assign out_reg_valid[l]              = srv[LAST];
        assign out_ptr[l*PTR_W +: PTR_W]     = sp[LAST];
        assign out_tag[l*TAG_W +: TAG_W]     = st[LAST];
        assign replay_valid[l]               = sv[RP] && !srv[RP] && !stall && !clear && !flushed(sp[RP]);
        assign replay_ptr[l*PTR_W +: PTR_W]  = sp[RP];
        assign replay_tag[l*TAG_W +: TAG_W]  = st[RP];
    end

endmodule

// File: tb/tb_fp_exec_pipe_ctrl.sv
// tb/tb_fp_exec_pipe_ctrl.sv - self-checking bench for fp_exec_pipe_ctrl
module tb_fp_exec_pipe_ctrl;
    localparam int LANES = 2;
    localparam int DEPTH = 3;
    localparam int PTR_W = 6;
    localparam int TAG_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n, stall, clear, flush_req, flush_all;
    logic [LANES-1:0]       in_valid, in_reg_valid, in_multi, mc_done;
    logic [LANES*PTR_W-1:0] in_ptr;
    logic [LANES*TAG_W-1:0] in_tag;
    logic [PTR_W-1:0]       flush_head, flush_tail;
    logic [LANES-1:0]       mc_start, mc_busy, out_valid, out_reg_valid, replay_valid;
    logic [LANES*PTR_W-1:0] out_ptr, replay_ptr;
    logic [LANES*TAG_W-1:0] out_tag, replay_tag;

    fp_exec_pipe_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear),
        .in_valid(in_valid), .in_reg_valid(in_reg_valid), .in_multi(in_multi),
        .in_ptr(in_ptr), .in_tag(in_tag),
        .flush_req(flush_req), .flush_all(flush_all),
        .flush_head(flush_head), .flush_tail(flush_tail),
        .mc_done(mc_done), .mc_start(mc_start), .mc_busy(mc_busy),
        .out_valid(out_valid), .out_reg_valid(out_reg_valid),
        .out_ptr(out_ptr), .out_tag(out_tag),
        .replay_valid(replay_valid), .replay_ptr(replay_ptr), .replay_tag(replay_tag)
    );

    typedef struct {
        int               lane;
        int               stage;
        logic [PTR_W-1:0] ptr;
        logic [TAG_W-1:0] tag;
        bit               rv;
        bit               multi;
    } op_t;

    op_t              ops[$];
    logic [PTR_W-1:0] seen0[$];
    int               tests = 0;
    int               fails = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Membership by modular distance from head: p is inside when it lies
    // fewer steps past head than the range length.
    function automatic bit fl(input logic [PTR_W-1:0] p);
        int d, len;
        if (!flush_req) return 1'b0;
        if (flush_all) return 1'b1;
        d   = (int'(p) - int'(flush_head) + 64) % 64;
        len = (int'(flush_tail) - int'(flush_head) + 64) % 64;
        return d < len;
    endfunction

    task automatic sample();
        @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            bit  fo, fr, e;
            op_t lo, ro;
            fo = 1'b0;
            fr = 1'b0;
            foreach (ops[i]) begin
                if (ops[i].lane == l && ops[i].stage == DEPTH-1) begin fo = 1'b1; lo = ops[i]; end
                if (ops[i].lane == l && ops[i].stage == 1)       begin fr = 1'b1; ro = ops[i]; end
            end
            e = fo && !stall && !clear && !fl(lo.ptr);
            chk("out_valid", 64'(out_valid[l]), 64'(e));
            if (out_valid[l] && l == 0) seen0.push_back(out_ptr[PTR_W-1:0]);
            if (fo) begin
                chk("out_ptr", 64'(out_ptr[l*PTR_W +: PTR_W]), 64'(lo.ptr));
                chk("out_tag", 64'(out_tag[l*TAG_W +: TAG_W]), 64'(lo.tag));
                if (!lo.multi) chk("out_reg_valid", 64'(out_reg_valid[l]), 64'(lo.rv));
            end
            if (!fr) begin
                chk("replay_idle", 64'(replay_valid[l]), 64'd0);
            end else begin
                chk("replay_ptr", 64'(replay_ptr[l*PTR_W +: PTR_W]), 64'(ro.ptr));
                chk("replay_tag", 64'(replay_tag[l*TAG_W +: TAG_W]), 64'(ro.tag));
                if (!ro.multi)
                    chk("replay_valid", 64'(replay_valid[l]), 64'(!ro.rv && !stall && !clear && !fl(ro.ptr)));
            end
        end
    endtask

    task automatic tick();
        op_t nq[$];
        @(posedge clk);
        if (!rst_n || clear) begin
            ops.delete();
        end else if (!stall) begin
            foreach (ops[i]) begin
                if (ops[i].stage < DEPTH-1 && !fl(ops[i].ptr)) begin
                    op_t o;
                    o = ops[i];
                    o.stage++;
                    nq.push_back(o);
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (in_valid[l] && !fl(in_ptr[l*PTR_W +: PTR_W]))
                    nq.push_back('{lane: l, stage: 0, ptr: in_ptr[l*PTR_W +: PTR_W],
                                   tag: in_tag[l*TAG_W +: TAG_W], rv: in_reg_valid[l], multi: in_multi[l]});
            end
            ops = nq;
        end
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic idle_in();
        in_valid = '0; in_reg_valid = '0; in_multi = '0;
        in_ptr = '0; in_tag = '0;
        flush_req = 1'b0; flush_all = 1'b0; flush_head = '0; flush_tail = '0;
        stall = 1'b0; clear = 1'b0;
    endtask

    task automatic issue(input int l, input logic [PTR_W-1:0] p, input logic [TAG_W-1:0] t,
                         input bit rv, input bit mu);
        in_valid[l]                 = 1'b1;
        in_reg_valid[l]             = rv;
        in_multi[l]                 = mu;
        in_ptr[l*PTR_W +: PTR_W]    = p;
        in_tag[l*TAG_W +: TAG_W]    = t;
    endtask

    initial begin
        rst_n = 1'b0;
        mc_done = '0;
        idle_in();
        step();
        step();
        rst_n = 1'b1;

        // reset state
        sample();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mc_busy", 64'(mc_busy), 64'd0);
        chk("rst_mc_start", 64'(mc_start), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        tick();

        // basic non-multi op, DEPTH-cycle latency
        issue(0, 6'd5, 32'hA5, 1'b1, 1'b0);
        step();
        idle_in();
        step();
        step();
        sample();
        chk("lat_out_valid", 64'(out_valid[0]), 64'd1);
        chk("lat_out_tag", 64'(out_tag[31:0]), 64'hA5);
        chk("lat_out_rv", 64'(out_reg_valid[0]), 64'd1);
        tick();

        // operands not ready -> replay from stage 1
        issue(0, 6'd7, 32'h77, 1'b0, 1'b0);
        step();
        idle_in();
        step();
        sample();
        chk("rp_valid", 64'(replay_valid[0]), 64'd1);
        chk("rp_ptr", 64'(replay_ptr[5:0]), 64'd7);
        tick();
        sample();
        chk("rp_out_valid", 64'(out_valid[0]), 64'd1);
        chk("rp_out_rv", 64'(out_reg_valid[0]), 64'd0);
        tick();

        // wrapping flush range [60, 2)
        seen0.delete();
        issue(0, 6'd61, 32'h61, 1'b1, 1'b0); step();
        issue(0, 6'd1,  32'h01, 1'b1, 1'b0); step();
        issue(0, 6'd3,  32'h03, 1'b1, 1'b0); step();
        idle_in();
        flush_req = 1'b1; flush_head = 6'd60; flush_tail = 6'd2;
        step();
        idle_in();
        repeat (4) step();
        chk("wrap_count", 64'(seen0.size()), 64'd1);
        if (seen0.size() > 0) chk("wrap_ptr", 64'(seen0[0]), 64'd3);

        // multicycle op: start, wait, reissue, release
        issue(0, 6'd9, 32'h99, 1'b1, 1'b1);
        sample();
        chk("mc_start_pulse", 64'(mc_start[0]), 64'd1);
        tick();
        idle_in();
        sample();
        chk("mc_start_once", 64'(mc_start[0]), 64'd0);
        chk("mc_busy_set", 64'(mc_busy[0]), 64'd1);
        tick();
        repeat (8) step();
        mc_done[0] = 1'b1;
        step();
        mc_done[0] = 1'b0;
        sample();
        chk("mc_busy_done", 64'(mc_busy[0]), 64'd1);
        tick();
        issue(0, 6'd9, 32'h99, 1'b1, 1'b1);
        sample();
        chk("mc_no_restart", 64'(mc_start[0]), 64'd0);
        tick();
        idle_in();
        step();
        step();
        sample();
        chk("mc_out_valid", 64'(out_valid[0]), 64'd1);
        chk("mc_out_rv", 64'(out_reg_valid[0]), 64'd1);
        chk("mc_busy_pre_rel", 64'(mc_busy[0]), 64'd1);
        tick();
        sample();
        chk("mc_busy_released", 64'(mc_busy[0]), 64'd0);
        tick();

        // flush owner while BUSY -> DRAIN until mc_done
        issue(0, 6'd9, 32'h99, 1'b1, 1'b1);
        step();
        idle_in();
        step();
        flush_req = 1'b1; flush_head = 6'd9; flush_tail = 6'd10;
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("drain_busy", 64'(mc_busy[0]), 64'd1);
            tick();
        end
        mc_done[0] = 1'b1;
        step();
        mc_done[0] = 1'b0;
        sample();
        chk("drain_idle", 64'(mc_busy[0]), 64'd0);
        tick();

        // stall mid-pipe
        issue(0, 6'd20, 32'h2020, 1'b1, 1'b0);
        step();
        idle_in();
        step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("stall_out_valid", 64'(out_valid[0]), 64'd0);
            chk("stall_rp_ptr", 64'(replay_ptr[5:0]), 64'd20);
            tick();
        end
        stall = 1'b0;
        step();
        sample();
        chk("stall_resume_valid", 64'(out_valid[0]), 64'd1);
        chk("stall_resume_tag", 64'(out_tag[31:0]), 64'h2020);
        tick();

        // reset while DONE with ops in flight
        issue(0, 6'd12, 32'h12, 1'b1, 1'b1);
        step();
        idle_in();
        step();
        mc_done[0] = 1'b1;
        step();
        mc_done[0] = 1'b0;
        issue(1, 6'd30, 32'h30, 1'b1, 1'b0); step();
        issue(0, 6'd31, 32'h31, 1'b0, 1'b0); step();
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_mc_busy", 64'(mc_busy), 64'd0);
        chk("rst2_replay", 64'(replay_valid), 64'd0);
        chk("rst2_out_rv", 64'(out_reg_valid), 64'd0);
        chk("rst2_out_ptr", 64'(out_ptr), 64'd0);
        tick();
        mc_done = '1;
        step();
        mc_done = '0;
        sample();
        chk("rst2_done_ignored", 64'(mc_busy), 64'd0);
        tick();

        // randomized non-multi traffic with stall, clear and flushes
        for (int c = 0; c < 400; c++) begin
            stall      = ($urandom % 5) == 0;
            clear      = ($urandom % 20) == 0;
            flush_req  = ($urandom % 6) == 0;
            flush_all  = ($urandom % 4) == 0;
            flush_head = PTR_W'($urandom);
            flush_tail = PTR_W'($urandom);
            for (int l = 0; l < LANES; l++) begin
                in_valid[l]              = ($urandom % 4) != 0;
                in_reg_valid[l]          = ($urandom % 3) != 0;
                in_multi[l]              = 1'b0;
                in_ptr[l*PTR_W +: PTR_W] = PTR_W'($urandom);
                in_tag[l*TAG_W +: TAG_W] = $urandom;
            end
            sample();
            chk("rand_mc_start", 64'(mc_start), 64'd0);
            chk("rand_mc_busy", 64'(mc_busy), 64'd0);
            tick();
        end
        idle_in();
        repeat (DEPTH + 1) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
